// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared enums for the execute stage
//   alu_op_e    : operation handed to the alu
//   src_a_sel_e : alu operand A source (rs1 / pc / zero)
//   src_b_sel_e : alu operand B source (rs2 / imm / four)
//   fwd_sel_e   : which pipeline stage supplies a source register
package ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_RS1,
    SRC_A_PC,
    SRC_A_ZERO
  } src_a_sel_e;

  typedef enum logic [1:0] {
    SRC_B_RS2,
    SRC_B_IMM,
    SRC_B_FOUR
  } src_b_sel_e;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_EX,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

endpackage

// File: rtl/ex_fwd_mux.sv
// rtl/ex_fwd_mux.sv - per-source-register forward select (macro RISCV_FWD_EN)
//   rs_addr/rs_data          : source index and S1-latched register data
//   ex_*/mem_*/wb_*          : writer valid, destination index and data per stage
//   sel                      : youngest matching stage, FWD_NONE if none or x0
//   value                    : operand value (bypassed only when RISCV_FWD_EN)
module ex_fwd_mux
  import ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic [RF_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]  rs_data,
  input  logic             ex_valid,
  input  logic [RF_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_data,
  input  logic             mem_valid,
  input  logic [RF_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             wb_valid,
  input  logic [RF_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output fwd_sel_e         sel,
  output logic [XLEN-1:0]  value
);

  // x0 never matches, so a write to x0 can never leak into a reader.
  always_comb begin
    sel = FWD_NONE;
    if (rs_addr != '0) begin
      if (ex_valid && (ex_rd == rs_addr))
        sel = FWD_EX;
      else if (mem_valid && (mem_rd == rs_addr))
        sel = FWD_MEM;
      else if (wb_valid && (wb_rd == rs_addr))
        sel = FWD_WB;
    end
  end

`ifdef RISCV_FWD_EN
  always_comb begin
    value = '0;
    if (rs_addr != '0) begin
      case (sel)
        FWD_EX:  value = ex_data;
        FWD_MEM: value = mem_data;
        FWD_WB:  value = wb_data;
        default: value = rs_data;
      endcase
    end
  end
`else
  // Without bypassing, sel is only used by the top to stall.
  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_data, mem_data, wb_data};
  assign value = (rs_addr == '0) ? '0 : rs_data;
`endif

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ID/EX latch, RAW resolution, EX/MEM latch (macro RISCV_FWD_EN)
//   clk, rst_n                : clock, asynchronous active-low reset
//   flush                     : kill S1 and EX/MEM next edge
//   id_*                      : decoded instruction with valid/ready handshake
//   mem_fwd_*, wb_fwd_*       : later-stage results for forwarding / hazard checks
//   alu_src_a/b, alu_op       : combinational drive to the alu; alu_result returns same cycle
//   ex_*                      : EX/MEM register with valid/ready handshake toward MEM
//   RISCV_FWD_EN defined      : bypass from EX/MEM, MEM, WB
//   RISCV_FWD_EN undefined    : stall until the register file holds the operand
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [RF_AW-1:0] id_rs1_addr,
  input  logic [RF_AW-1:0] id_rs2_addr,
  input  logic [RF_AW-1:0] id_rd_addr,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  alu_op_e          id_alu_op,
  input  src_a_sel_e       id_src_a_sel,
  input  src_b_sel_e       id_src_b_sel,
  input  logic             id_reg_write,
  input  logic             mem_fwd_valid,
  input  logic [RF_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]  mem_fwd_data,
  input  logic             mem_fwd_busy,
  input  logic             wb_fwd_valid,
  input  logic [RF_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]  wb_fwd_data,
  output logic [XLEN-1:0]  alu_src_a,
  output logic [XLEN-1:0]  alu_src_b,
  output alu_op_e          alu_op,
  input  logic [XLEN-1:0]  alu_result,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_result,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RF_AW-1:0] ex_rd_addr,
  output logic             ex_reg_write
);

  logic             s1_valid;
  logic [XLEN-1:0]  s1_pc;
  logic [XLEN-1:0]  s1_imm;
  logic [XLEN-1:0]  s1_rs1_data;
  logic [XLEN-1:0]  s1_rs2_data;
  logic [RF_AW-1:0] s1_rs1_addr;
  logic [RF_AW-1:0] s1_rs2_addr;
  logic [RF_AW-1:0] s1_rd_addr;
  alu_op_e          s1_alu_op;
  src_a_sel_e       s1_src_a_sel;
  src_b_sel_e       s1_src_b_sel;
  logic             s1_reg_write;

  fwd_sel_e         rs1_sel;
  fwd_sel_e         rs2_sel;
  logic [XLEN-1:0]  fwd_rs1;
  logic [XLEN-1:0]  fwd_rs2;

  logic             rs1_used;
  logic             busy_stall;
  logic             raw_stall;
  logic             hazard_stall;
  logic             s1_adv;

  // The latched operands act as a copy of the register file: a WB write
  // landing at or after acceptance must update them, otherwise a value that
  // retires while the instruction waits in S1 would be lost.
  logic             wb_hit_id_rs1;
  logic             wb_hit_id_rs2;
  logic             wb_hit_s1_rs1;
  logic             wb_hit_s1_rs2;

  assign wb_hit_id_rs1 = wb_fwd_valid && (wb_fwd_rd == id_rs1_addr) && (id_rs1_addr != '0);
  assign wb_hit_id_rs2 = wb_fwd_valid && (wb_fwd_rd == id_rs2_addr) && (id_rs2_addr != '0);
  assign wb_hit_s1_rs1 = wb_fwd_valid && (wb_fwd_rd == s1_rs1_addr) && (s1_rs1_addr != '0);
  assign wb_hit_s1_rs2 = wb_fwd_valid && (wb_fwd_rd == s1_rs2_addr) && (s1_rs2_addr != '0);

  ex_fwd_mux #(.XLEN(XLEN), .RF_AW(RF_AW)) u_fwd_rs1 (
    .rs_addr   (s1_rs1_addr),
    .rs_data   (s1_rs1_data),
    .ex_valid  (ex_valid && ex_reg_write),
    .ex_rd     (ex_rd_addr),
    .ex_data   (ex_result),
    .mem_valid (mem_fwd_valid),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .wb_valid  (wb_fwd_valid),
    .wb_rd     (wb_fwd_rd),
    .wb_data   (wb_fwd_data),
    .sel       (rs1_sel),
    .value     (fwd_rs1)
  );

  ex_fwd_mux #(.XLEN(XLEN), .RF_AW(RF_AW)) u_fwd_rs2 (
    .rs_addr   (s1_rs2_addr),
    .rs_data   (s1_rs2_data),
    .ex_valid  (ex_valid && ex_reg_write),
    .ex_rd     (ex_rd_addr),
    .ex_data   (ex_result),
    .mem_valid (mem_fwd_valid),
    .mem_rd    (mem_fwd_rd),
    .mem_data  (mem_fwd_data),
    .wb_valid  (wb_fwd_valid),
    .wb_rd     (wb_fwd_rd),
    .wb_data   (wb_fwd_data),
    .sel       (rs2_sel),
    .value     (fwd_rs2)
  );

  // rs2 is always live because it doubles as store data.
  assign rs1_used   = (s1_src_a_sel == SRC_A_RS1);
  assign busy_stall = mem_fwd_busy && (mem_fwd_rd != '0) &&
                      ((rs1_used && (s1_rs1_addr == mem_fwd_rd)) || (s1_rs2_addr == mem_fwd_rd));

`ifdef RISCV_FWD_EN
  logic unused_fwd_sel;
  assign unused_fwd_sel = ^{rs1_sel, rs2_sel};
  assign raw_stall      = 1'b0;
`else
  assign raw_stall = (rs1_used && (rs1_sel != FWD_NONE)) || (rs2_sel != FWD_NONE);
`endif

  assign hazard_stall = s1_valid && (busy_stall || raw_stall);
  assign s1_adv       = s1_valid && !hazard_stall && (!ex_valid || ex_ready);
  assign id_ready     = !s1_valid || s1_adv;

  always_comb begin
    alu_src_a = fwd_rs1;
    case (s1_src_a_sel)
      SRC_A_PC:   alu_src_a = s1_pc;
      SRC_A_ZERO: alu_src_a = '0;
      default:    alu_src_a = fwd_rs1;
    endcase
    alu_src_b = fwd_rs2;
    case (s1_src_b_sel)
      SRC_B_IMM:  alu_src_b = s1_imm;
      SRC_B_FOUR: alu_src_b = XLEN'(4);
      default:    alu_src_b = fwd_rs2;
    endcase
    alu_op = s1_valid ? s1_alu_op : ALU_ADD;
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_pc        <= '0;
      s1_imm       <= '0;
      s1_rs1_data  <= '0;
      s1_rs2_data  <= '0;
      s1_rs1_addr  <= '0;
      s1_rs2_addr  <= '0;
      s1_rd_addr   <= '0;
      s1_alu_op    <= ALU_ADD;
      s1_src_a_sel <= SRC_A_RS1;
      s1_src_b_sel <= SRC_B_RS2;
      s1_reg_write <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (id_valid && id_ready) begin
      s1_valid     <= 1'b1;
      s1_pc        <= id_pc;
      s1_imm       <= id_imm;
      s1_rs1_data  <= wb_hit_id_rs1 ? wb_fwd_data : id_rs1_data;
      s1_rs2_data  <= wb_hit_id_rs2 ? wb_fwd_data : id_rs2_data;
      s1_rs1_addr  <= id_rs1_addr;
      s1_rs2_addr  <= id_rs2_addr;
      s1_rd_addr   <= id_rd_addr;
      s1_alu_op    <= id_alu_op;
      s1_src_a_sel <= id_src_a_sel;
      s1_src_b_sel <= id_src_b_sel;
      s1_reg_write <= id_reg_write;
    end else begin
      if (s1_adv)
        s1_valid <= 1'b0;
      if (wb_hit_s1_rs1)
        s1_rs1_data <= wb_fwd_data;
      if (wb_hit_s1_rs2)
        s1_rs2_data <= wb_fwd_data;
    end
  end

  // EX/MEM register; data holds whenever nothing new advances into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_result     <= '0;
      ex_store_data <= '0;
      ex_rd_addr    <= '0;
      ex_reg_write  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (s1_adv) begin
      ex_valid      <= 1'b1;
      ex_pc         <= s1_pc;
      ex_result     <= alu_result;
      ex_store_data <= fwd_rs2;
      ex_rd_addr    <= s1_rd_addr;
      ex_reg_write  <= s1_reg_write;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized architectural-model bench for ex_stage
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  alu_op_e     id_alu_op;
  src_a_sel_e  id_src_a_sel;
  src_b_sel_e  id_src_b_sel;
  logic        id_reg_write;
  logic        mem_fwd_valid, mem_fwd_busy, wb_fwd_valid;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  alu_op_e     alu_op;
  logic        ex_valid, ex_ready, ex_reg_write;
  logic [31:0] ex_pc, ex_result, ex_store_data;
  logic [4:0]  ex_rd_addr;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .RF_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
    .id_reg_write(id_reg_write),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .mem_fwd_busy(mem_fwd_busy),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .alu_result(alu_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  function automatic logic [31:0] alu_f(alu_op_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      default:  return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_src_a, alu_src_b);

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    alu_op_e     op;
    src_a_sel_e  sa;
    src_b_sel_e  sb;
    logic        rw;
  } ins_t;

  typedef struct {
    logic [31:0] pc, result, store;
    logic [4:0]  rd;
    logic        rw;
    int          seq, acc_cyc;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural state: arch_rf follows program order at acceptance,
  // arch_commit follows what MEM has taken (flush rolls back to it),
  // env_rf is the register file the decode stage reads.
  logic [31:0] arch_rf[8], arch_commit[8], env_rf[8];
  exp_t        expq[$];
  ins_t        dirq[$];
  ins_t        cur;
  logic        have_cur;
  logic [31:0] next_pc = 32'h1000;
  int          seq = 0;

  // environment MEM and WB stages
  logic        mem_v, mem_rw, wb_v, wb_rw;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_data, wb_data;
  int          mem_busy;

  function automatic ins_t mk(alu_op_e op, int rd, int rs1, int rs2, src_a_sel_e sa,
                              src_b_sel_e sb, logic [31:0] imm);
    ins_t i;
    i.pc = 0; i.imm = imm; i.op = op; i.sa = sa; i.sb = sb; i.rw = 1'b1;
    i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
    i.rs1 = 5'($urandom_range(0, 7));
    i.rs2 = 5'($urandom_range(0, 7));
    i.rd  = 5'($urandom_range(0, 7));
    i.op  = alu_op_e'(4'($urandom_range(0, 9)));
    i.sa  = src_a_sel_e'(2'($urandom_range(0, 2)));
    i.sb  = src_b_sel_e'(2'($urandom_range(0, 2)));
    i.rw  = ($urandom_range(0, 4) != 0);
    i.pc  = 0;
    return i;
  endfunction

  function automatic exp_t model(ins_t i, int s, int c);
    exp_t e;
    logic [31:0] a, b;
    a = (i.sa == SRC_A_RS1) ? arch_rf[i.rs1[2:0]] : (i.sa == SRC_A_PC) ? i.pc : 32'h0;
    b = (i.sb == SRC_B_RS2) ? arch_rf[i.rs2[2:0]] : (i.sb == SRC_B_IMM) ? i.imm : 32'd4;
    e.pc = i.pc; e.result = alu_f(i.op, a, b); e.store = arch_rf[i.rs2[2:0]];
    e.rd = i.rd; e.rw = i.rw; e.seq = s; e.acc_cyc = c;
    return e;
  endfunction

  initial begin
    logic        directed, acc, con, mem_go, hold;
    logic [31:0] held_result, held_pc;
    int          last_prog;
    exp_t        e;

    flush = 0; id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_op = ALU_ADD;
    id_src_a_sel = SRC_A_RS1; id_src_b_sel = SRC_B_RS2; id_reg_write = 0;
    mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0; mem_fwd_busy = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0; ex_ready = 1;
    mem_v = 0; mem_rw = 0; mem_rd = 0; mem_data = 0; mem_busy = 0;
    wb_v = 0; wb_rw = 0; wb_rd = 0; wb_data = 0;
    have_cur = 0; hold = 0; held_result = 0; held_pc = 0; last_prog = 0;

    for (int r = 0; r < 8; r++) arch_rf[r] = $urandom;
    arch_rf[0] = 0; arch_rf[1] = 5; arch_rf[2] = 7;
    for (int r = 0; r < 8; r++) begin arch_commit[r] = arch_rf[r]; env_rf[r] = arch_rf[r]; end

    // ADD x3,x1,x2 ; SUB x4,x3,x1 ; x0 write then x0 read ; pc/four forms
    dirq.push_back(mk(ALU_ADD, 3, 1, 2, SRC_A_RS1, SRC_B_RS2, 0));
    dirq.push_back(mk(ALU_SUB, 4, 3, 1, SRC_A_RS1, SRC_B_RS2, 0));
    dirq.push_back(mk(ALU_ADD, 0, 1, 2, SRC_A_RS1, SRC_B_RS2, 0));
    dirq.push_back(mk(ALU_ADD, 5, 0, 1, SRC_A_RS1, SRC_B_RS2, 0));
    dirq.push_back(mk(ALU_ADD, 6, 0, 0, SRC_A_PC, SRC_B_FOUR, 0));
    dirq.push_back(mk(ALU_XOR, 7, 4, 5, SRC_A_RS1, SRC_B_IMM, 32'h55));

    repeat (3) @(posedge clk);
    #1;
    check("rst_id_ready", 32'(id_ready), 1);
    check("rst_ex_valid", 32'(ex_valid), 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_ex_result", ex_result, 0);
    check("rst_ex_store_data", ex_store_data, 0);
    check("rst_ex_rd_addr", 32'(ex_rd_addr), 0);
    check("rst_ex_reg_write", 32'(ex_reg_write), 0);
    check("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    rst_n = 1;

    for (int c = 0; c < 4000; c++) begin
      directed = (c < 40);
      // drive
      if (!have_cur && (directed || $urandom_range(0, 4) != 0)) begin
        if (dirq.size() > 0) cur = dirq.pop_front();
        else if (!directed) cur = rand_ins();
        else cur.pc = 32'hx;
        if (directed && dirq.size() == 0 && cur.pc !== 32'hx) have_cur = 1;
        else if (!directed || cur.pc === 32'hx) have_cur = !directed;
        else have_cur = 1;
        if (have_cur) begin cur.pc = next_pc; next_pc += 4; end
      end
      id_valid     = have_cur;
      id_pc        = cur.pc;
      id_rs1_addr  = cur.rs1;
      id_rs2_addr  = cur.rs2;
      id_rd_addr   = cur.rd;
      id_imm       = cur.imm;
      id_alu_op    = cur.op;
      id_src_a_sel = cur.sa;
      id_src_b_sel = cur.sb;
      id_reg_write = cur.rw;
      id_rs1_data  = env_rf[cur.rs1[2:0]];
      id_rs2_data  = env_rf[cur.rs2[2:0]];
      mem_go       = mem_v && (mem_busy == 0) && (directed || $urandom_range(0, 3) != 0);
      ex_ready     = (!mem_v || mem_go) && (directed || $urandom_range(0, 4) != 0);
      flush        = !directed && ($urandom_range(0, 39) == 0);
      mem_fwd_valid = mem_v && mem_rw && (mem_busy == 0);
      mem_fwd_busy  = mem_v && mem_rw && (mem_busy > 0);
      mem_fwd_rd    = mem_rd;
      mem_fwd_data  = (mem_busy > 0) ? $urandom : mem_data;
      wb_fwd_valid  = wb_v && wb_rw;
      wb_fwd_rd     = wb_rd;
      wb_fwd_data   = wb_data;

      @(negedge clk);
      if (hold) begin
        check("hold_ex_valid", 32'(ex_valid), 1);
        check("hold_ex_result", ex_result, held_result);
        check("hold_ex_pc", ex_pc, held_pc);
      end
      if (expq.size() == 0) check("id_ready_empty", 32'(id_ready), 1);
      if (expq.size() == 2 && ex_valid && !ex_ready) check("id_ready_full", 32'(id_ready), 0);

      acc = id_valid && id_ready && !flush;
      con = ex_valid && ex_ready && !flush;
      if (con) begin
        last_prog = c;
        if (expq.size() == 0) begin
          check("spurious_ex_valid", 32'(ex_valid), 0);
        end else begin
          e = expq.pop_front();
          check("ex_pc", ex_pc, e.pc);
          check("ex_result", ex_result, e.result);
          check("ex_store_data", ex_store_data, e.store);
          check("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
          check("ex_reg_write", 32'(ex_reg_write), 32'(e.rw));
          if (e.seq == 0) check("latency", 32'(c - e.acc_cyc), 2);
          if (e.rw && e.rd != 0) arch_commit[e.rd[2:0]] = e.result;
        end
      end
      if (acc) begin
        e = model(cur, seq, c);
        seq++;
        expq.push_back(e);
        if (cur.rw && cur.rd != 0) arch_rf[cur.rd[2:0]] = e.result;
        have_cur = 0;
      end
      if (flush) begin
        expq.delete();
        for (int r = 0; r < 8; r++) arch_rf[r] = arch_commit[r];
        have_cur = 0;
      end
      hold = ex_valid && !ex_ready && !flush;
      held_result = ex_result;
      held_pc = ex_pc;
      if (expq.size() == 0) last_prog = c;
      if (c - last_prog > 400) begin
        check("watchdog_progress", 32'(c - last_prog), 0);
        break;
      end

      @(posedge clk);
      if (wb_v && wb_rw && wb_rd != 0) env_rf[wb_rd[2:0]] = wb_data;
      wb_v = mem_go; wb_rw = mem_rw; wb_rd = mem_rd; wb_data = mem_data;
      if (mem_v && mem_busy > 0) mem_busy--;
      if (con) begin
        mem_v = 1; mem_rw = ex_reg_write; mem_rd = ex_rd_addr; mem_data = ex_result;
        mem_busy = (!directed && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end else if (mem_go) begin
        mem_v = 0;
      end
      #1;
    end

    // asynchronous reset in the middle of a cycle
    flush = 0; id_valid = 1; ex_ready = 0; mem_fwd_busy = 0; mem_fwd_valid = 0; wb_fwd_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("async_rst_ex_valid", 32'(ex_valid), 0);
    check("async_rst_id_ready", 32'(id_ready), 1);
    check("async_rst_ex_result", ex_result, 0);
    check("async_rst_ex_pc", ex_pc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute-stage pipeline shell of the RISC-V core, between decode and memory.
- Latches the decoded instruction (ID/EX register) and resolves RAW hazards by forwarding.
- Drives operands and op to the alu combinationally and captures alu.result into the EX/MEM register.
- valid/ready handshakes on both sides; flush support.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RF_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill both internal stages (branch redirect)
- id_valid  in  1  decode offers instruction
- id_ready  out  1  stage accepts instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RF_AW  register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_op  in  alu_op_e  operation
- id_src_a_sel  in  src_a_sel_e  SRC_A_RS1 / SRC_A_PC / SRC_A_ZERO
- id_src_b_sel  in  src_b_sel_e  SRC_B_RS2 / SRC_B_IMM / SRC_B_FOUR
- id_reg_write  in  1  instruction writes rd
- mem_fwd_valid, mem_fwd_rd, mem_fwd_data  in  1/RF_AW/XLEN  MEM-stage result available
- mem_fwd_busy  in  1  MEM holds a load to mem_fwd_rd whose data is not yet ready
- wb_fwd_valid, wb_fwd_rd, wb_fwd_data  in  1/RF_AW/XLEN  WB-stage result
- alu_src_a, alu_src_b  out  XLEN  operands to alu
- alu_op  out  alu_op_e  operation to alu
- alu_result  in  XLEN  alu output, same cycle
- ex_valid  out  1  EX/MEM holds a result
- ex_ready  in  1  MEM consumes it
- ex_pc, ex_result, ex_store_data  out  XLEN  registered PC, alu result, forwarded rs2
- ex_rd_addr  out  RF_AW
- ex_reg_write  out  1

Behaviour:
- Reset:
  - s1_valid=0, ex_valid=0.
  - All registered data outputs = 0; ex_rd_addr=0; ex_reg_write=0.
  - id_ready=1.
- S1 (ID/EX) register:
  - Loads when id_valid && id_ready.
  - id_ready = !s1_valid || s1_adv.
- S1 advance:
  - s1_adv = s1_valid && !hazard_stall && (!ex_valid || ex_ready).
  - On s1_adv, EX/MEM captures alu_result, pc, rd, reg_write and forwarded rs2.
- EX/MEM register:
  - ex_valid clears on ex_ready && !s1_adv.
  - Data registers are held while ex_valid && !ex_ready.
- Latency: an accepted instruction presents ex_valid 2 cycles after acceptance, absent stalls. Full throughput is 1 instr/cycle.
- Forward priority, per source register, highest first:
  1. EX/MEM (ex_valid && ex_reg_write && ex_rd_addr==rs)
  2. MEM (mem_fwd_valid)
  3. WB (wb_fwd_valid)
  4. S1 latched register data
- Register x0 is never forwarded; it always reads 0.
- Operand select:
  - alu_src_a = fwd_rs1 / s1_pc / 0.
  - alu_src_b = fwd_rs2 / s1_imm / 4.
  - alu_op = s1 op (ALU_ADD when !s1_valid).
- hazard_stall = s1_valid && mem_fwd_busy && a used source register equals mem_fwd_rd (!=0).
  - rs1 counts as used only for SRC_A_RS1.
  - rs2 counts as used for SRC_B_RS2, and always as store data.
- flush (synchronous, has priority):
  - s1_valid and ex_valid clear next edge.
  - An id_valid in the flush cycle is dropped.
- Reset mid-operation: everything returns to reset values immediately, asynchronously.

Optional Feature:
- Macro RISCV_FWD_EN.
- Defined: forwarding as above.
- Undefined: no bypass muxes; operands come from S1 data only.
  - hazard_stall additionally asserts while any used source register (!=0) matches a valid writing rd in EX/MEM, MEM or WB.
  - The instruction waits until the register file holds the value.

Decomposition:
- riscv/types.sv gains:
  - src_a_sel_e, src_b_sel_e;
  - fwd_sel_e: FWD_NONE, FWD_EX, FWD_MEM, FWD_WB.
- Sub-module ex_fwd_mux: one instance per source register. Compares addresses, returns fwd_sel_e plus the selected value.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, ex_ready=1 -> ex_valid after 2 cycles, ex_result=12, ex_rd_addr=3.
- Back-to-back: ADD x3 (=12), then SUB x4,x3,x1 with stale rs1 data 0 -> EX forward gives ex_result=7; WB-only match with wb_fwd_data=9 yields 4.
- mem_fwd_busy with mem_fwd_rd=3, next instruction reads x3 -> id_ready=0 and no ex_valid for each busy cycle; resumes when busy drops, with mem_fwd_data value used.
- ex_ready=0 for 3 cycles with 2 instructions in flight -> ex_result stable, id_ready=0, no loss or duplication after release.
- flush while both stages valid -> ex_valid=0 next cycle, no result emitted; write to x0 is never forwarded (next reader of x0 gets 0).
- Without RISCV_FWD_EN, the scenario-2 sequence -> stall until WB clears, then ex_result=7 via register data.
